// File: rtl/time_pkg.sv
// Shared constants and types for the seconds-of-day time keeper and its
// hours/minutes/seconds converter.
package time_pkg;
  localparam int TIME_BUFF_SIZE = 18;
  localparam int OPER_L         = 3;
  localparam int AMT_W          = TIME_BUFF_SIZE + 1;
  localparam int OPER_W         = AMT_W + OPER_L;

  localparam logic [OPER_L-1:0] RESET_OPCODE = 3'd0;
  localparam logic [OPER_L-1:0] DEC_OPCODE   = 3'd1;
  localparam logic [OPER_L-1:0] ADD_OPCODE   = 3'd2;

  localparam int HOUR_SEC    = 3600;
  localparam int MINUTE_SEC  = 60;
  localparam int SECOND_SEC  = 1;
  localparam int DAY_SECONDS = 86400;

  typedef enum logic [1:0] {IDLE, HOUR, MIN, DONE} conv_state_t;
endpackage

// File: rtl/sec_to_hms.sv
// Iterative seconds -> h/m/s converter: repeated subtraction of 3600 then 60,
// publishing all three fields together in DONE.
module sec_to_hms
  import time_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [TIME_BUFF_SIZE-1:0] snapshot,
  output logic                      ready,
  output logic                      done,
  output logic [4:0]                hours,
  output logic [5:0]                minutes,
  output logic [5:0]                seconds
);
  localparam logic [TIME_BUFF_SIZE-1:0] HOUR_L = TIME_BUFF_SIZE'(HOUR_SEC);
  localparam logic [TIME_BUFF_SIZE-1:0] MIN_L  = TIME_BUFF_SIZE'(MINUTE_SEC);

  conv_state_t               state, next_state;
  logic [TIME_BUFF_SIZE-1:0] rem;
  logic [4:0]                h_cnt;
  logic [5:0]                m_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) next_state = HOUR;
      end
      HOUR: if (rem < HOUR_L) next_state = MIN;
      MIN:  if (rem < MIN_L)  next_state = DONE;
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Working registers carry no reset: they are always loaded in IDLE before use.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        rem   <= snapshot;
        h_cnt <= '0;
        m_cnt <= '0;
      end
      HOUR: if (rem >= HOUR_L) begin
        rem   <= rem - HOUR_L;
        h_cnt <= h_cnt + 5'd1;
      end
      MIN: if (rem >= MIN_L) begin
        rem   <= rem - MIN_L;
        m_cnt <= m_cnt + 6'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hours   <= '0;
      minutes <= '0;
      seconds <= '0;
    end else if (state == DONE) begin
      hours   <= h_cnt;
      minutes <= m_cnt;
      seconds <= rem[5:0];
    end
  end
endmodule

// File: rtl/time_keeper.sv
// Seconds-of-day counter driven by OPER commands and a 1 Hz tick, with a
// display-field converter and a TIME_VALID flag tracking field freshness.
module time_keeper
  import time_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [OPER_W-1:0]         OPER,
  input  logic                      OPER_VALID,
  input  logic                      TICK_1HZ,
  output logic [TIME_BUFF_SIZE-1:0] TOTAL_SEC,
  output logic [4:0]                HOURS,
  output logic [5:0]                MINUTES,
  output logic [5:0]                SECONDS,
  output logic                      TIME_VALID,
  output logic                      ERR
);
  localparam logic [AMT_W-1:0] DAY_W = AMT_W'(DAY_SECONDS);

  function automatic logic [AMT_W-1:0] add_mod(input logic [AMT_W-1:0] t,
                                               input logic [AMT_W-1:0] a);
    logic [AMT_W-1:0] sum;
    sum = t + a;
    return (sum >= DAY_W) ? sum - DAY_W : sum;
  endfunction

  function automatic logic [AMT_W-1:0] sub_mod(input logic [AMT_W-1:0] t,
                                               input logic [AMT_W-1:0] a);
    return (t >= a) ? t - a : t + DAY_W - a;
  endfunction

  logic [OPER_L-1:0]         opcode;
  logic [AMT_W-1:0]          amt;
  logic [AMT_W-1:0]          cur;
  logic [AMT_W-1:0]          next_total;
  logic                      amt_ok;
  logic                      cmd_err;
  logic                      pend, next_pend;
  logic                      changed;
  logic                      dirty;
  logic                      conv_ready, conv_done;

  assign opcode = OPER[OPER_L-1:0];
  assign amt    = OPER[TIME_BUFF_SIZE+OPER_L:OPER_L];
  assign cur    = {1'b0, TOTAL_SEC};
  assign amt_ok = amt < DAY_W;

  // A command owns its cycle; a coincident tick is parked and applied on the
  // next command-free cycle.
  always_comb begin
    next_total = cur;
    next_pend  = pend;
    cmd_err    = 1'b0;
    if (OPER_VALID) begin
      case (opcode)
        RESET_OPCODE: next_total = '0;
        DEC_OPCODE:   if (amt_ok) next_total = sub_mod(cur, amt); else cmd_err = 1'b1;
        ADD_OPCODE:   if (amt_ok) next_total = add_mod(cur, amt); else cmd_err = 1'b1;
        default:      cmd_err = 1'b1;
      endcase
      if (TICK_1HZ) next_pend = 1'b1;
    end else if (TICK_1HZ || pend) begin
      next_total = add_mod(cur, AMT_W'(SECOND_SEC));
      next_pend  = 1'b0;
    end
  end

  assign changed = next_total != cur;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      TOTAL_SEC  <= '0;
      pend       <= 1'b0;
      ERR        <= 1'b0;
      dirty      <= 1'b0;
      TIME_VALID <= 1'b1;
    end else begin
      TOTAL_SEC <= next_total[TIME_BUFF_SIZE-1:0];
      pend      <= next_pend;
      ERR       <= cmd_err;
      dirty     <= changed | (dirty & ~conv_ready);
      // A change landing on the DONE edge must still leave the fields marked stale.
      if (changed)        TIME_VALID <= 1'b0;
      else if (conv_done) TIME_VALID <= ~dirty;
    end
  end

  sec_to_hms u_conv (
    .clk      (CLK),
    .rst_n    (RST_N),
    .start    (dirty),
    .snapshot (TOTAL_SEC),
    .ready    (conv_ready),
    .done     (conv_done),
    .hours    (HOURS),
    .minutes  (MINUTES),
    .seconds  (SECONDS)
  );
endmodule
